// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter handing one byte at a time to a UART transmitter
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   ack,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic               timeout_err
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, SEND, RELEASE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, idx_q, idx_d, sel;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic timeout_err_q, timeout_err_d;
  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int k);
    return PW'((int'(p) + k) % N_REQ);
  endfunction
  // scan from farthest to nearest so the first requester after ptr wins
  always_comb begin
    sel = ptr_q;
    for (int k = N_REQ; k >= 1; k--) sel = req[wrap(ptr_q, k)] ? wrap(ptr_q, k) : sel;
  end
  // next-state logic: pick, launch with timeout, send, release with ack
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    idx_d         = idx_q;
    grant_d       = grant_q;
    tx_data_d     = tx_data_q;
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: if (|req) begin
        state_d   = LAUNCH;
        idx_d     = sel;
        grant_d   = N_REQ'(1) << sel;
        tx_data_d = req_data[{sel, 3'b000} +: 8];
        cnt_d     = '0;
      end
      LAUNCH: begin
        cnt_d = cnt_q + 1'b1;
        if (tx_busy) state_d = SEND;
        else if (cnt_d == CW'(TIMEOUT)) begin
          state_d       = IDLE;
          grant_d       = '0;
          timeout_err_d = 1'b1;
        end
      end
      SEND: state_d = tx_busy ? SEND : RELEASE;
      default: begin
        state_d = IDLE;
        ptr_d   = idx_q;
        grant_d = '0;
      end
    endcase
  end
  // state registers; reset points ptr at the last requester so requester 0 goes first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= PW'(N_REQ - 1);
      idx_q         <= '0;
      grant_q       <= '0;
      tx_data_q     <= '0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      idx_q         <= idx_d;
      grant_q       <= grant_d;
      tx_data_q     <= tx_data_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign grant       = grant_q;
  assign ack         = (state_q == RELEASE) ? grant_q : '0;
  assign tx_start    = (state_q == LAUNCH) || (state_q == SEND);
  assign tx_data     = tx_data_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized self-checking bench with a transaction-level arbiter model
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int T = 16;
  logic clk = 1'b0, reset = 1'b0, tx_busy = 1'b0;
  logic [N-1:0] req = '0, grant, ack;
  logic [8*N-1:0] req_data;
  logic tx_start, timeout_err;
  logic [7:0] tx_data;
  logic [7:0] bytes [N];
  int n_chk = 0, n_pass = 0;
  int mptr, wait_n, d1, d2, xcnt;
  logic [N-1:0] pg;
  logic pst, got_busy, fell, xdone, dead, rnd, hold_all;
  logic [7:0] cur_data;
  logic [7:0] sent [$];

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .grant(grant), .ack(ack),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .timeout_err(timeout_err));

  always #5 clk = ~clk;
  always_comb for (int i = 0; i < N; i++) req_data[8*i +: 8] = bytes[i];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int rr(input int p, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) if (((r >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
    return -1;
  endfunction

  function automatic int idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g == (N'(1) << i)) return i;
    return -1;
  endfunction

  task automatic monitor();
    int e;
    chk("grant_onehot", $onehot0(grant), 1);
    chk("ack_in_grant", $onehot0(ack) && ((ack & ~grant) == '0), 1);
    if (pg == '0) begin
      e = rr(mptr, req);
      chk("grant_pick", grant, (e < 0) ? '0 : N'(1) << e);
      chk("ack_idle", ack, 0);
      chk("to_idle", timeout_err, 0);
      if (e >= 0) begin
        chk("gap", pst, 0);
        chk("start_launch", tx_start, 1);
        chk("data_pick", tx_data, bytes[e]);
        cur_data = bytes[e];
        sent.push_back(tx_data);
        wait_n = 1; got_busy = 1'b0; fell = 1'b0;
      end else chk("start_idle", tx_start, 0);
    end else if (fell) begin
      chk("grant_rel", grant, 0); chk("ack_rel", ack, 0);
      chk("start_rel", tx_start, 0); chk("to_rel", timeout_err, 0);
    end else if (got_busy) begin
      chk("grant_send", grant, pg);
      chk("to_send", timeout_err, 0);
      if (!tx_busy) begin
        chk("ack_pulse", ack, pg); chk("start_drop", tx_start, 0);
        fell = 1'b1; mptr = idx(pg);
      end else begin
        chk("ack_send", ack, 0); chk("start_send", tx_start, 1);
      end
    end else if (tx_busy) begin
      got_busy = 1'b1;
      chk("grant_busy", grant, pg); chk("start_busy", tx_start, 1);
      chk("ack_busy", ack, 0); chk("to_busy", timeout_err, 0);
    end else if (wait_n == T) begin
      chk("grant_to", grant, 0); chk("to_pulse", timeout_err, 1);
      chk("start_to", tx_start, 0); chk("ack_to", ack, 0);
    end else begin
      wait_n++;
      chk("grant_wait", grant, pg); chk("start_wait", tx_start, 1);
      chk("ack_wait", ack, 0); chk("to_wait", timeout_err, 0);
    end
    chk("data_hold", tx_data, cur_data);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    monitor();
    if (!tx_start) begin
      xdone = 1'b0; xcnt = 0; tx_busy = 1'b0;
    end else begin
      if (!pst && rnd) begin
        d1 = $urandom_range(1, 4); d2 = $urandom_range(1, 12); dead = ($urandom_range(15) == 0);
      end
      if (tx_busy) begin
        xcnt++;
        if (xcnt >= d2) begin tx_busy = 1'b0; xdone = 1'b1; end
      end else if (!xdone && !dead) begin
        xcnt++;
        if (xcnt >= d1) begin tx_busy = 1'b1; xcnt = 0; end
      end
    end
    if (!hold_all) req = req & ~ack;
    if (rnd)
      for (int i = 0; i < N; i++)
        if (!req[i] && !ack[i] && $urandom_range(3) == 0) begin
          bytes[i] = 8'($urandom); req[i] = 1'b1;
        end
    pg = grant; pst = tx_start;
  endtask

  task automatic do_reset();
    #3 reset = 1'b1;
    #1;
    chk("rst_grant", grant, 0); chk("rst_ack", ack, 0); chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 0); chk("rst_to", timeout_err, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mptr = N - 1; pg = '0; pst = 1'b0; cur_data = '0; tx_busy = 1'b0;
    xdone = 1'b0; xcnt = 0; fell = 1'b0; got_busy = 1'b0; wait_n = 0;
  endtask

  initial begin
    int n, nto, nack;
    logic [7:0] exp_seq [5];
    exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    for (int i = 0; i < N; i++) bytes[i] = '0;
    rnd = 1'b0; hold_all = 1'b0; dead = 1'b0; d1 = 2; d2 = 10;
    do_reset();
    bytes[0] = 8'hA5; req = 4'b0001; nack = 0;
    for (int c = 0; c < 40; c++) begin step(); if (ack == 4'b0001) nack++; end
    chk("t1_acks", nack, 1);
    chk("t1_data", tx_data, 8'hA5);
    do_reset();
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    hold_all = 1'b1; req = 4'b1111; sent.delete();
    for (int c = 0; c < 300 && sent.size() < 5; c++) step();
    chk("t2_count", sent.size() >= 5, 1);
    for (int i = 0; i < 5 && i < sent.size(); i++) chk("t2_seq", sent[i], exp_seq[i]);
    hold_all = 1'b0; req = '0;
    do_reset();
    dead = 1'b1; req = 4'b0010; n = 0; nto = 0;
    for (int c = 0; c < 60 && nto == 0; c++) begin
      step();
      if (tx_start) n++;
      if (timeout_err) nto++;
    end
    chk("t3_launch_cycles", n, T);
    chk("t3_timeouts", nto, 1);
    step();
    chk("t3_regrant", grant, 4'b0010);
    dead = 1'b0; req = '0;
    do_reset();
    bytes[2] = 8'h5C; req = 4'b0100;
    for (int c = 0; c < 40 && !(tx_busy && grant == 4'b0100); c++) step();
    chk("t4_in_send", tx_busy && grant == 4'b0100, 1);
    repeat (3) step();
    req[2] = 1'b0; nack = 0;
    for (int c = 0; c < 40; c++) begin step(); if (ack == 4'b0100) nack++; end
    chk("t4_ack", nack, 1);
    do_reset();
    bytes[0] = 8'h3C; bytes[1] = 8'h7E; req = 4'b0010;
    for (int c = 0; c < 40 && !(tx_busy && grant == 4'b0010); c++) step();
    chk("t5_in_send", tx_busy && grant == 4'b0010, 1);
    req = 4'b0011;
    repeat (2) step();
    do_reset();
    step();
    chk("t5_first_grant", grant, 4'b0001);
    req = '0;
    do_reset();
    rnd = 1'b1;
    repeat (3000) step();
    rnd = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
